sec_counter_ctrl: RTL and testbench

Run-control sequencer for the seconds counter datapath. It converts the system clock into a one-cycle seconds tick through a prescaler, and gates counting with an IDLE/RUN/PAUSE state machine driven by start, stop and clear commands. It captures lap snapshots and muxes live or lap value onto the display bus under Slt. It sits between the board push-button/switch inputs and the 64-bit seconds count/display path.

---
 rtl/sec_counter_ctrl.sv | 146 ++++++++++++++
 tb/tb_sec_counter_ctrl.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sec_counter_ctrl.sv
// Run-control sequencer for the seconds counter.
// A prescaler divides Clk down to a one-cycle seconds tick.
// An IDLE/RUN/PAUSE state machine gates counting and is driven by the
// Start/Stop/Clear level commands, where Clear beats Stop and Stop beats Start.
// Lap captures the live count, and Slt selects the live or lap value for display.
module sec_counter_ctrl #(
  parameter int unsigned DIV_CYCLES = 32'd50000000,
  parameter int          PRE_W      = 32
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        Start,
  input  logic        Stop,
  input  logic        Clear,
  input  logic        Lap,
  input  logic        Slt,
  output logic        Tick,
  output logic        Running,
  output logic [1:0]  State,
  output logic [63:0] Sec,
  output logic [63:0] LapSec,
  output logic [63:0] Disp,
  output logic        Ovf
);

  // Last prescaler value of a second; the next RUN edge wraps and ticks.
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV_CYCLES - 32'd1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_BAD   = 2'b11
  } state_t;

  state_t           state_reg, state_next;
  logic [PRE_W-1:0] pre_reg, pre_next;
  logic [63:0]      sec_reg, sec_next;
  logic [63:0]      lap_reg, lap_next;
  logic             tick_reg, tick_next;
  logic             ovf_reg, ovf_next;
  logic             wrap;
  logic             start_eff;

  // A second elapses on this edge only when counting in RUN at the last prescaler value.
  assign wrap = (state_reg == ST_RUN) && (pre_reg == PRE_LAST);

  // Stop outranks Start, so a coincident Stop suppresses a Start.
  assign start_eff = Start && !Stop;

  // Next-state, prescaler, counters and lap; all decisions use pre-edge state.
  always_comb begin
    state_next = state_reg;
    pre_next   = pre_reg;
    sec_next   = sec_reg;
    lap_next   = lap_reg;
    tick_next  = 1'b0;
    ovf_next   = ovf_reg;

    if (Clear) begin
      // Clear wins over everything, including a coincident tick or lap.
      state_next = ST_IDLE;
      pre_next   = '0;
      sec_next   = '0;
      lap_next   = '0;
      ovf_next   = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start_eff) begin
            state_next = ST_RUN;
            pre_next   = '0;
          end
        end

        ST_RUN: begin
          if (wrap) begin
            pre_next  = '0;
            sec_next  = sec_reg + 64'd1;
            tick_next = 1'b1;
            if (&sec_reg) begin
              ovf_next = 1'b1;
            end
          end else begin
            pre_next = pre_reg + PRE_W'(1);
          end
          // The count for this edge still happens; the pause takes effect afterwards.
          if (Stop) begin
            state_next = ST_PAUSE;
          end
          // Snapshot excludes any increment landing on this same edge.
          if (Lap) begin
            lap_next = sec_reg;
          end
        end

        ST_PAUSE: begin
          // Partial second is kept in the prescaler across the pause.
          if (start_eff) begin
            state_next = ST_RUN;
          end
          if (Lap) begin
            lap_next = sec_reg;
          end
        end

        default: begin
          // Unused encoding: fall back to a clean IDLE.
          state_next = ST_IDLE;
          pre_next   = '0;
          sec_next   = '0;
          lap_next   = '0;
          ovf_next   = 1'b0;
        end
      endcase
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= ST_IDLE;
      pre_reg   <= '0;
      sec_reg   <= '0;
      lap_reg   <= '0;
      tick_reg  <= 1'b0;
      ovf_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      pre_reg   <= pre_next;
      sec_reg   <= sec_next;
      lap_reg   <= lap_next;
      tick_reg  <= tick_next;
      ovf_reg   <= ovf_next;
    end
  end

  assign Tick    = tick_reg;
  assign Running = (state_reg == ST_RUN);
  assign State   = state_reg;
  assign Sec     = sec_reg;
  assign LapSec  = lap_reg;
  assign Ovf     = ovf_reg;
  assign Disp    = Slt ? lap_reg : sec_reg;

endmodule

// File: tb/tb_sec_counter_ctrl.sv
// Self-checking bench for sec_counter_ctrl with DIV_CYCLES=4.
// A cycle-level behavioural model is advanced on every rising edge from the same inputs.
module tb_sec_counter_ctrl;

  localparam int DIV = 4;
  localparam longint unsigned SEC_MAX = 64'hFFFF_FFFF_FFFF_FFFF;
  localparam int M_IDLE  = 0;
  localparam int M_RUN   = 1;
  localparam int M_PAUSE = 2;

  logic        Clk, Reset, Start, Stop, Clear, Lap, Slt;
  logic        Tick, Running, Ovf;
  logic [1:0]  State;
  logic [63:0] Sec, LapSec, Disp;

  int total = 0;
  int bad   = 0;

  // Behavioural model: mode, cycles elapsed in current second, counts.
  int              m_mode  = M_IDLE;
  int              m_phase = 0;
  longint unsigned m_sec   = 0;
  longint unsigned m_lap   = 0;
  bit              m_tick  = 0;
  bit              m_ovf   = 0;

  sec_counter_ctrl #(.DIV_CYCLES(DIV), .PRE_W(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Stop(Stop), .Clear(Clear),
    .Lap(Lap), .Slt(Slt), .Tick(Tick), .Running(Running), .State(State),
    .Sec(Sec), .LapSec(LapSec), .Disp(Disp), .Ovf(Ovf)
  );

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  function automatic logic [1:0] mode_code(input int mode);
    if (mode == M_RUN)   return 2'b01;
    if (mode == M_PAUSE) return 2'b10;
    return 2'b00;
  endfunction

  task model_step();
    if (Reset || Clear) begin
      m_mode = M_IDLE; m_phase = 0; m_sec = 0; m_lap = 0; m_tick = 0; m_ovf = 0;
    end else begin
      m_tick = 0;
      if (Lap && m_mode != M_IDLE) m_lap = m_sec;
      if (m_mode == M_RUN) begin
        m_phase = m_phase + 1;
        if (m_phase == DIV) begin
          m_phase = 0;
          m_tick  = 1;
          if (m_sec == SEC_MAX) m_ovf = 1;
          m_sec = m_sec + 1;
        end
        if (Stop) m_mode = M_PAUSE;
      end else if (m_mode == M_PAUSE) begin
        if (Start && !Stop) m_mode = M_RUN;
      end else begin
        if (Start && !Stop) begin m_mode = M_RUN; m_phase = 0; end
      end
    end
  endtask

  // One clock: model advances on the edge, outputs are sampled 1 time unit later.
  task automatic cyc();
    @(posedge Clk);
    model_step();
    #1;
  endtask

  task automatic quiet();
    Reset = 0; Start = 0; Stop = 0; Clear = 0; Lap = 0;
  endtask

  task automatic test_reset();
    quiet(); Slt = 0; Reset = 1;
    cyc(); cyc();
    Reset = 0;
    total++; if (State !== 2'b00) begin bad++; $display("FAIL reset_state got=%b want=00", State); end
    total++; if (Sec !== 64'd0) begin bad++; $display("FAIL reset_sec got=%0d want=0", Sec); end
    total++; if (LapSec !== 64'd0) begin bad++; $display("FAIL reset_lap got=%0d want=0", LapSec); end
    total++; if (Tick !== 1'b0 || Ovf !== 1'b0 || Running !== 1'b0) begin
      bad++; $display("FAIL reset_flags got tick=%b ovf=%b run=%b want 0 0 0", Tick, Ovf, Running);
    end
    $display("test_reset: state=%b sec=%0d", State, Sec);
  endtask

  task automatic test_tick_latency();
    Start = 1; cyc(); Start = 0;
    for (int i = 1; i <= 3 * DIV; i++) begin
      cyc();
      total++; if (Tick !== ((i % DIV) == 0)) begin
        bad++; $display("FAIL tick_latency edge=%0d got=%b want=%b", i, Tick, (i % DIV) == 0);
      end
      total++; if (Sec !== 64'(i / DIV)) begin
        bad++; $display("FAIL tick_sec edge=%0d got=%0d want=%0d", i, Sec, i / DIV);
      end
      total++; if (Running !== 1'b1 || State !== 2'b01) begin
        bad++; $display("FAIL tick_running edge=%0d got run=%b state=%b want 1 01", i, Running, State);
      end
    end
    $display("test_tick_latency: sec=%0d", Sec);
  endtask

  task automatic test_pause_resume();
    int held_phase;
    longint unsigned held_sec;
    int k;
    bit seen;
    cyc(); cyc();
    Stop = 1; cyc(); Stop = 0;
    held_phase = m_phase;
    held_sec   = m_sec;
    for (int i = 0; i < 20; i++) begin
      cyc();
      total++; if (Sec !== held_sec || Tick !== 1'b0 || State !== 2'b10) begin
        bad++; $display("FAIL pause_hold cyc=%0d got sec=%0d tick=%b state=%b want sec=%0d tick=0 state=10",
                        i, Sec, Tick, State, held_sec);
      end
    end
    Start = 1; cyc(); Start = 0;
    k = 0; seen = 0;
    while (!seen && k < 3 * DIV) begin
      cyc(); k++;
      if (Tick) seen = 1;
    end
    total++; if (!seen || k != DIV - held_phase) begin
      bad++; $display("FAIL resume_latency got=%0d seen=%b want=%0d", k, seen, DIV - held_phase);
    end
    total++; if (Sec !== held_sec + 1) begin
      bad++; $display("FAIL resume_sec got=%0d want=%0d", Sec, held_sec + 1);
    end
    $display("test_pause_resume: resumed after %0d cycles sec=%0d", k, Sec);
  endtask

  task automatic test_lap_disp();
    longint unsigned prev;
    int k = 0;
    while (!(m_mode == M_RUN && m_phase == DIV - 1) && k < 3 * DIV) begin cyc(); k++; end
    prev = m_sec;
    Lap = 1; cyc(); Lap = 0;
    total++; if (LapSec !== prev) begin bad++; $display("FAIL lap_value got=%0d want=%0d", LapSec, prev); end
    total++; if (Sec !== prev + 1 || Tick !== 1'b1) begin
      bad++; $display("FAIL lap_wrap got sec=%0d tick=%b want sec=%0d tick=1", Sec, Tick, prev + 1);
    end
    Slt = 1; #1;
    total++; if (Disp !== prev) begin bad++; $display("FAIL disp_lap got=%0d want=%0d", Disp, prev); end
    Slt = 0; #1;
    total++; if (Disp !== prev + 1) begin bad++; $display("FAIL disp_live got=%0d want=%0d", Disp, prev + 1); end
    $display("test_lap_disp: lap=%0d sec=%0d", LapSec, Sec);
  endtask

  task automatic test_clear_priority();
    int k = 0;
    while (!(m_mode == M_RUN && m_phase == DIV - 1) && k < 3 * DIV) begin cyc(); k++; end
    Clear = 1; Stop = 1; Lap = 1; cyc(); quiet();
    total++; if (State !== 2'b00 || Sec !== 64'd0 || LapSec !== 64'd0 || Tick !== 1'b0 || Ovf !== 1'b0) begin
      bad++; $display("FAIL clear_priority got state=%b sec=%0d lap=%0d tick=%b ovf=%b want all zero",
                      State, Sec, LapSec, Tick, Ovf);
    end
    Lap = 1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      total++; if (LapSec !== 64'd0 || State !== 2'b00) begin
        bad++; $display("FAIL idle_lap got lap=%0d state=%b want 0 00", LapSec, State);
      end
    end
    Lap = 0;
    $display("test_clear_priority: state=%b sec=%0d", State, Sec);
  endtask

  task automatic test_overflow();
    int k = 0;
    bit seen = 0;
    Start = 1; cyc(); Start = 0;
    force dut.sec_reg = 64'hFFFF_FFFF_FFFF_FFFF;
    m_sec = SEC_MAX;
    #1;
    release dut.sec_reg;
    while (!seen && k < 3 * DIV) begin cyc(); k++; if (Tick) seen = 1; end
    total++; if (!seen || Sec !== 64'd0 || Ovf !== 1'b1) begin
      bad++; $display("FAIL overflow_wrap got seen=%b sec=%0d ovf=%b want 1 0 1", seen, Sec, Ovf);
    end
    Stop = 1; cyc(); Stop = 0;
    cyc(); cyc();
    Start = 1; cyc(); Start = 0;
    for (int i = 0; i < 2 * DIV; i++) begin
      cyc();
      total++; if (Ovf !== 1'b1) begin bad++; $display("FAIL overflow_sticky cyc=%0d got=%b want=1", i, Ovf); end
    end
    Clear = 1; cyc(); Clear = 0;
    total++; if (Ovf !== 1'b0) begin bad++; $display("FAIL overflow_clear got=%b want=0", Ovf); end
    $display("test_overflow: ovf=%b sec=%0d", Ovf, Sec);
  endtask

  task automatic test_reset_mid_run();
    int k = 0;
    bit seen = 0;
    Start = 1; cyc(); Start = 0;
    while (!(m_sec == 3 && m_phase == 2) && k < 40) begin cyc(); k++; end
    total++; if (Sec !== 64'd3) begin bad++; $display("FAIL midrun_setup got=%0d want=3", Sec); end
    Reset = 1; cyc(); Reset = 0;
    total++; if (State !== 2'b00 || Sec !== 64'd0 || LapSec !== 64'd0 || Tick !== 1'b0 ||
                 Ovf !== 1'b0 || Running !== 1'b0) begin
      bad++; $display("FAIL midrun_reset got state=%b sec=%0d lap=%0d tick=%b ovf=%b run=%b want all zero",
                      State, Sec, LapSec, Tick, Ovf, Running);
    end
    cyc();
    Start = 1; cyc(); Start = 0;
    k = 0;
    while (!seen && k < 3 * DIV) begin cyc(); k++; if (Tick) seen = 1; end
    total++; if (!seen || k != DIV) begin
      bad++; $display("FAIL restart_latency got=%0d seen=%b want=%0d", k, seen, DIV);
    end
    $display("test_reset_mid_run: restart tick after %0d cycles", k);
  endtask

  task automatic test_random();
    longint unsigned want_disp;
    for (int i = 0; i < 600; i++) begin
      Reset = ($urandom_range(0, 63) == 0);
      Clear = ($urandom_range(0, 31) == 0);
      Start = ($urandom_range(0, 3) == 0);
      Stop  = ($urandom_range(0, 7) == 0);
      Lap   = ($urandom_range(0, 3) == 0);
      Slt   = $urandom_range(0, 1);
      cyc();
      want_disp = Slt ? m_lap : m_sec;
      total++;
      if (State !== mode_code(m_mode) || Running !== (m_mode == M_RUN) || Tick !== m_tick ||
          Sec !== m_sec || LapSec !== m_lap || Ovf !== m_ovf || Disp !== want_disp) begin
        bad++;
        $display("FAIL random cyc=%0d got st=%b run=%b tick=%b sec=%0d lap=%0d ovf=%b disp=%0d want st=%b run=%b tick=%b sec=%0d lap=%0d ovf=%b disp=%0d",
                 i, State, Running, Tick, Sec, LapSec, Ovf, Disp,
                 mode_code(m_mode), m_mode == M_RUN, m_tick, m_sec, m_lap, m_ovf, want_disp);
      end
    end
    quiet();
    $display("test_random: final sec=%0d lap=%0d", Sec, LapSec);
  endtask

  initial begin
    quiet();
    Slt = 0;
    test_reset();
    test_tick_latency();
    test_pause_resume();
    test_lap_disp();
    test_clear_priority();
    test_overflow();
    test_reset_mid_run();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
